dht11_ascii_reporter: RTL and testbench
=======================================

DHT11_ASCII_REPORTER -- requirements
Module: dht11_ascii_reporter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Port: clk  in  1  system clock (100 MHz); all logic on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Ports: temp_start / humi_start  in  1 each  single-cycle request pulses for the temperature / humidity report.
REQ-005 Ports: i_max_temp, i_min_temp, i_max_humi, i_min_humi  in  8 each  unsigned min/max statistics from the max/min stage.
REQ-006 Port: tx_busy  in  1  UART transmitter busy; high while a byte is shifting.
REQ-007 Ports: tx_start  out  1  one-cycle byte-launch strobe; tx_data  out  8  byte, valid while tx_start=1.
REQ-008 Ports: busy  out  1  high from request acceptance to last byte complete; done  out  1  one-cycle pulse after the last byte.

Function
REQ-009 Message SHALL be 19 ASCII bytes: channel char ('T' 0x54 or 'H' 0x48), " MAX=", 3 decimal digits of max, " MIN=", 3 decimal digits of min, 0x0D, 0x0A.
REQ-010 Digits SHALL always be 3 wide with leading zeros (0 -> "000", 255 -> "255").
REQ-011 On acceptance, the selected channel's max and min SHALL be snapshotted; later input changes do not affect the message in flight.
REQ-012 FSM states: IDLE, CONV, SEND, WAIT_ACK, WAIT_DONE, FIN.
REQ-013 IDLE: accept a request if a start pulse or pending flag is present -> CONV; busy rises the next cycle.
REQ-014 CONV: sequential binary-to-BCD conversion of max then min, 8 cycles each (double-dabble); exit to SEND after exactly 16 cycles.
REQ-015 SEND: when tx_busy=0, drive tx_start=1 for one cycle with tx_data = message[idx] -> WAIT_ACK; while tx_busy=1, hold.
REQ-016 WAIT_ACK: wait for tx_busy=1 -> WAIT_DONE; WAIT_DONE: wait for tx_busy=0, then idx+1 -> SEND, or if idx=18 -> FIN.
REQ-017 FIN: done=1 for one cycle, busy=0, idx cleared -> IDLE.
REQ-018 Byte index SHALL be 5 bits, range 0..18, no wrap beyond 18.
REQ-019 Simultaneous temp_start and humi_start: temperature served first; humidity set pending and served immediately after.
REQ-020 A start pulse while busy SHALL set that channel's one-deep pending flag; repeated pulses for an already-pending channel are dropped.
REQ-021 A start pulse for the channel currently being sent SHALL set its pending flag (report repeats with fresh snapshot).
REQ-022 Pending priority from IDLE: temperature before humidity; a pending flag clears on acceptance.
REQ-023 tx_data SHALL hold its last value between strobes; tx_start never asserts outside SEND.

Reset
REQ-024 On reset=0: state=IDLE, idx=0, pending flags=0, snapshots=0, tx_start=0, tx_data=0x00, busy=0, done=0.
REQ-025 Reset mid-message SHALL abort immediately; no further tx_start after release until a new start pulse.
REQ-026 Start pulses coincident with reset asserted SHALL be ignored.

Structure
REQ-027 Shared package dht11_report_pkg SHALL hold the state enum, MSG_LEN=19, and ASCII constants (CH_T, CH_H, CR, LF, '0' offset).
REQ-028 One sub-module bin2bcd8 (start/done handshake, 8-bit in, 12-bit BCD out, 8-cycle sequential double-dabble), instantiated once and reused for max and min.
REQ-029 Message byte selection SHALL be a combinational mux on idx; no ROM.

Verification
REQ-030 i_max_temp=27, i_min_temp=19, temp_start pulse, UART model busy 10 cycles/byte -> bytes "T MAX=027 MIN=019" 0D 0A, then done pulse, busy low.
REQ-031 i_max_humi=255, i_min_humi=0, humi_start -> "H MAX=255 MIN=000" 0D 0A; first tx_start exactly 18 cycles after the start pulse.
REQ-032 temp_start and humi_start same cycle -> full T message, then full H message, two done pulses, no bytes interleaved.
REQ-033 Three humi_start pulses during a T message -> exactly one H message follows; inputs changed mid-T do not alter the T digits.
REQ-034 reset low during byte 7 -> tx_start stays 0, busy=0, all outputs at reset values; after release, no output until a new start.
REQ-035 tx_busy held high for 500 cycles before byte 0 -> tx_start withheld until tx_busy falls, then message completes unchanged.

Source files
------------

// File: rtl/dht11_ascii_reporter_pkg.sv
// Shared types and constants for the DHT11 ASCII report path: FSM states,
// message length and the ASCII characters used to build each report line.
package dht11_report_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        FIN
    } state_e;

    localparam int unsigned MSG_LEN  = 19;
    localparam logic [4:0]  LAST_IDX = 5'(MSG_LEN - 1);

    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_H     = 8'h48;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_M  = 8'h4D;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_X  = 8'h58;
    localparam logic [7:0] ASCII_I  = 8'h49;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    function automatic logic [7:0] bcd_char(input logic [3:0] nib);
        return ASCII_0 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/dht11_ascii_reporter_if.sv
// Request, statistics and UART byte-launch signals of the ASCII reporter.
// The reporter itself sits on the slave modport.
interface dht11_ascii_reporter_if;

    logic       temp_start;
    logic       humi_start;
    logic [7:0] i_max_temp;
    logic [7:0] i_min_temp;
    logic [7:0] i_max_humi;
    logic [7:0] i_min_humi;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;

    modport master (
        output temp_start, humi_start,
        output i_max_temp, i_min_temp, i_max_humi, i_min_humi,
        output tx_busy,
        input  tx_start, tx_data, busy, done
    );

    modport slave (
        input  temp_start, humi_start,
        input  i_max_temp, i_min_temp, i_max_humi, i_min_humi,
        input  tx_busy,
        output tx_start, tx_data, busy, done
    );

endinterface

// File: rtl/dht11_ascii_reporter_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// The first shift happens in the start cycle, so a result is ready after 8 cycles.
module bin2bcd8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] sreg_q, sreg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [19:0] step_out;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [19:0] t;
        t = {add3(s[19:16]), add3(s[15:12]), add3(s[11:8]), s[7:0]};
        return {t[18:0], 1'b0};
    endfunction

    always_comb begin
        step_out = dabble(start ? {12'h000, bin} : sreg_q);
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done     = 1'b0;
        if (start) begin
            sreg_d = step_out;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            sreg_d = step_out;
            cnt_d  = cnt_q + 3'd1;
            // seventh step after start is the eighth shift overall
            if (cnt_q == 3'd6) begin
                run_d = 1'b0;
                done  = 1'b1;
            end
        end
        bcd = step_out[19:8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/dht11_ascii_reporter.sv
// Formats min/max temperature or humidity as a 19-byte ASCII line
// ("T MAX=ddd MIN=ddd\r\n") and pushes it byte by byte into a UART transmitter.
module dht11_ascii_reporter
    import dht11_report_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    dht11_ascii_reporter_if.slave bus
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        pend_t_q, pend_t_d;
    logic        pend_h_q, pend_h_d;
    logic        ch_h_q, ch_h_d;
    logic [7:0]  snap_max_q, snap_max_d;
    logic [7:0]  snap_min_q, snap_min_d;
    logic [3:0]  conv_cnt_q, conv_cnt_d;
    logic [11:0] max_bcd_q, max_bcd_d;
    logic [11:0] min_bcd_q, min_bcd_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        cv_start;
    logic        cv_done;
    logic [7:0]  cv_bin;
    logic [11:0] cv_bcd;
    logic [7:0]  msg_byte;

    // max converts in CONV cycles 0..7, min in 8..15
    assign cv_start = (state_q == CONV) && (conv_cnt_q[2:0] == 3'd0);
    assign cv_bin   = conv_cnt_q[3] ? snap_min_q : snap_max_q;

    bin2bcd8 u_bin2bcd8 (
        .clk   (clk),
        .reset (reset),
        .start (cv_start),
        .bin   (cv_bin),
        .done  (cv_done),
        .bcd   (cv_bcd)
    );

    always_comb begin
        msg_byte = 8'h00;
        case (idx_q)
            5'd0:    msg_byte = ch_h_q ? CH_H : CH_T;
            5'd1:    msg_byte = ASCII_SP;
            5'd2:    msg_byte = ASCII_M;
            5'd3:    msg_byte = ASCII_A;
            5'd4:    msg_byte = ASCII_X;
            5'd5:    msg_byte = ASCII_EQ;
            5'd6:    msg_byte = bcd_char(max_bcd_q[11:8]);
            5'd7:    msg_byte = bcd_char(max_bcd_q[7:4]);
            5'd8:    msg_byte = bcd_char(max_bcd_q[3:0]);
            5'd9:    msg_byte = ASCII_SP;
            5'd10:   msg_byte = ASCII_M;
            5'd11:   msg_byte = ASCII_I;
            5'd12:   msg_byte = ASCII_N;
            5'd13:   msg_byte = ASCII_EQ;
            5'd14:   msg_byte = bcd_char(min_bcd_q[11:8]);
            5'd15:   msg_byte = bcd_char(min_bcd_q[7:4]);
            5'd16:   msg_byte = bcd_char(min_bcd_q[3:0]);
            5'd17:   msg_byte = CR;
            5'd18:   msg_byte = LF;
            default: msg_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_t_d   = pend_t_q;
        pend_h_d   = pend_h_q;
        ch_h_d     = ch_h_q;
        snap_max_d = snap_max_q;
        snap_min_d = snap_min_q;
        conv_cnt_d = conv_cnt_q;
        max_bcd_d  = max_bcd_q;
        min_bcd_d  = min_bcd_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (state_q != IDLE) begin
            if (bus.temp_start) pend_t_d = 1'b1;
            if (bus.humi_start) pend_h_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.temp_start || pend_t_q) begin
                    ch_h_d     = 1'b0;
                    snap_max_d = bus.i_max_temp;
                    snap_min_d = bus.i_min_temp;
                    pend_t_d   = 1'b0;
                    pend_h_d   = pend_h_q | bus.humi_start;
                    conv_cnt_d = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end else if (bus.humi_start || pend_h_q) begin
                    ch_h_d     = 1'b1;
                    snap_max_d = bus.i_max_humi;
                    snap_min_d = bus.i_min_humi;
                    pend_h_d   = 1'b0;
                    conv_cnt_d = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                conv_cnt_d = conv_cnt_q + 4'd1;
                if (cv_done) begin
                    if (conv_cnt_q[3]) min_bcd_d = cv_bcd;
                    else               max_bcd_d = cv_bcd;
                end
                if (conv_cnt_q == 4'd15) state_d = SEND;
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = msg_byte;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = SEND;
                    end
                end
            end
            FIN: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_t_q   <= 1'b0;
            pend_h_q   <= 1'b0;
            ch_h_q     <= 1'b0;
            snap_max_q <= '0;
            snap_min_q <= '0;
            conv_cnt_q <= '0;
            max_bcd_q  <= '0;
            min_bcd_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_t_q   <= pend_t_d;
            pend_h_q   <= pend_h_d;
            ch_h_q     <= ch_h_d;
            snap_max_q <= snap_max_d;
            snap_min_q <= snap_min_d;
            conv_cnt_q <= conv_cnt_d;
            max_bcd_q  <= max_bcd_d;
            min_bcd_q  <= min_bcd_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_dht11_ascii_reporter.sv
// Directed bench for dht11_ascii_reporter: a 10-cycle UART model, a byte/done
// monitor and hand-written expected report lines.
module tb_dht11_ascii_reporter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_busy = 1'b0;
    logic        hold_busy = 1'b0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [7:0]  q_b[$];
    int unsigned q_c[$];

    dht11_ascii_reporter_if bus();

    assign bus.tx_busy = uart_busy | hold_busy;

    dht11_ascii_reporter dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            q_b.push_back(bus.tx_data);
            q_c.push_back(cyc);
        end
        if (bus.done) done_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_start) begin
                uart_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic h);
        tick();
        start_cyc = cyc;
        bus.temp_start = t;
        bus.humi_start = h;
        tick();
        bus.temp_start = 1'b0;
        bus.humi_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int limit);
        for (int k = 0; k < limit && q_b.size() < n; k++) tick();
        check("bytes_reached", 32'(q_b.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int target, input int limit);
        for (int k = 0; k < limit && done_cnt < target; k++) tick();
        check("done_cnt", 32'(done_cnt), 32'(target));
    endtask

    task automatic check_msg(input int base, input string s);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        for (int i = 0; i < s.len() + 2; i++) begin
            if (i < s.len()) exp_b = s[i];
            else             exp_b = (i == s.len()) ? 8'h0D : 8'h0A;
            got_b = (base + i < q_b.size()) ? q_b[base + i] : 8'h00;
            check($sformatf("byte%0d", i), 32'(got_b), 32'(exp_b));
        end
    endtask

    int base;
    int bd;
    int nb;

    initial begin
        bus.temp_start = 1'b0;
        bus.humi_start = 1'b0;
        bus.i_max_temp = 8'd0;
        bus.i_min_temp = 8'd0;
        bus.i_max_humi = 8'd0;
        bus.i_min_humi = 8'd0;

        // reset state, with a start pulse held during reset
        bus.temp_start = 1'b1;
        repeat (3) tick();
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        bus.temp_start = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (50) tick();
        check("rst_quiet_bytes", 32'(q_b.size()), 32'd0);
        check("rst_quiet_busy", 32'(bus.busy), 32'd0);

        // temperature report 27/19
        bus.i_max_temp = 8'd27;
        bus.i_min_temp = 8'd19;
        base = q_b.size();
        bd = done_cnt;
        check("idle_busy", 32'(bus.busy), 32'd0);
        pulse(1'b1, 1'b0);
        check("busy_rise", 32'(bus.busy), 32'd1);
        wait_done(bd + 1, 800);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check_msg(base, "T MAX=027 MIN=019");
        repeat (5) tick();
        check("single_done", 32'(done_cnt), 32'(bd + 1));
        check("tx_data_hold", 32'(bus.tx_data), 32'h0A);
        check("t_nbytes", 32'(q_b.size() - base), 32'd19);

        // humidity report 255/0 and first-byte latency
        bus.i_max_humi = 8'd255;
        bus.i_min_humi = 8'd0;
        base = q_b.size();
        bd = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done(bd + 1, 800);
        check("first_latency", (base < q_b.size()) ? q_c[base] - start_cyc : 32'hFFFF, 32'd18);
        check_msg(base, "H MAX=255 MIN=000");

        // simultaneous requests: T then H
        base = q_b.size();
        bd = done_cnt;
        pulse(1'b1, 1'b1);
        wait_done(bd + 2, 1600);
        check_msg(base, "T MAX=027 MIN=019");
        check_msg(base + 19, "H MAX=255 MIN=000");
        check("both_nbytes", 32'(q_b.size() - base), 32'd38);

        // repeated humi pulses and input changes during a T message
        bus.i_max_humi = 8'd60;
        bus.i_min_humi = 8'd45;
        base = q_b.size();
        bd = done_cnt;
        pulse(1'b1, 1'b0);
        wait_bytes(base + 3, 400);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1);
            tick();
        end
        bus.i_max_temp = 8'd99;
        bus.i_min_temp = 8'd88;
        wait_done(bd + 2, 1600);
        check_msg(base, "T MAX=027 MIN=019");
        check_msg(base + 19, "H MAX=060 MIN=045");
        repeat (300) tick();
        check("pend_nbytes", 32'(q_b.size() - base), 32'd38);
        check("pend_done", 32'(done_cnt), 32'(bd + 2));

        // reset during byte 7, with humidity pending and a start held in reset
        bus.i_max_temp = 8'd27;
        bus.i_min_temp = 8'd19;
        base = q_b.size();
        bd = done_cnt;
        pulse(1'b1, 1'b0);
        wait_bytes(base + 8, 400);
        pulse(1'b0, 1'b1);
        rst_n = 1'b0;
        bus.temp_start = 1'b1;
        #1;
        check("abort_tx_start", 32'(bus.tx_start), 32'd0);
        check("abort_tx_data", 32'(bus.tx_data), 32'h00);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        tick();
        bus.temp_start = 1'b0;
        tick();
        rst_n = 1'b1;
        nb = q_b.size();
        repeat (300) tick();
        check("abort_no_bytes", 32'(q_b.size()), 32'(nb));
        check("abort_idle_busy", 32'(bus.busy), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'(bd));

        // tx_busy held high before byte 0
        bus.i_max_temp = 8'd100;
        bus.i_min_temp = 8'd5;
        hold_busy = 1'b1;
        base = q_b.size();
        bd = done_cnt;
        pulse(1'b1, 1'b0);
        repeat (500) tick();
        check("held_no_bytes", 32'(q_b.size() - base), 32'd0);
        check("held_busy", 32'(bus.busy), 32'd1);
        hold_busy = 1'b0;
        wait_done(bd + 1, 800);
        check_msg(base, "T MAX=100 MIN=005");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
